// File: rtl/mpu_pkg.sv
// mpu_pkg
//   Definitions shared by the MPU matrix loader and the transpose stage:
//   element and matrix geometry, the loader state encoding, and the
//   row-major element offset helper.
package mpu_pkg;

    localparam int unsigned ELEM_W   = 8;
    localparam int unsigned DIM      = 5;
    localparam int unsigned MATRIX_W = ELEM_W * DIM * DIM;

    typedef enum logic {
        LOAD = 1'b0,
        HOLD = 1'b1
    } mpu_state_e;

    // Bit offset of element (i, j) in a flat row-major matrix:
    // ew * (j + dim * i), i.e. 8*(j+5*i) for the default geometry.
    function automatic int unsigned elem_offset(
        input int unsigned i,
        input int unsigned j,
        input int unsigned ew,
        input int unsigned dim
    );
        return ew * (j + dim * i);
    endfunction

endpackage

// File: rtl/mpu_matrix_loader.sv
// mpu_matrix_loader
//   Collects a stream of DIM*DIM signed elements into a flat row-major
//   matrix register and hands the complete matrix downstream with a
//   valid/ready handshake.
//
//   clk       : single clock, rising edge
//   rst_n     : asynchronous active-low reset
//   clear     : synchronous frame abort, highest priority
//   in_valid  : in_data holds an element
//   in_ready  : an element is accepted this cycle
//   in_data   : signed element
//   in_last   : producer mark on the final element of a frame
//   out_valid : matrix holds a complete frame
//   out_ready : downstream takes the matrix
//   matrix    : flat signed matrix, registered
//   count     : elements accepted in the current frame
//   err_len   : one-cycle framing-error pulse
module mpu_matrix_loader #(
    parameter int unsigned ELEM_W = mpu_pkg::ELEM_W,
    parameter int unsigned DIM    = mpu_pkg::DIM
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            clear,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic signed [ELEM_W-1:0]        in_data,
    input  logic                            in_last,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ELEM_W*DIM*DIM-1:0]       matrix,
    output logic [4:0]                      count,
    output logic                            err_len
);

    import mpu_pkg::mpu_state_e;
    import mpu_pkg::LOAD;
    import mpu_pkg::HOLD;
    import mpu_pkg::elem_offset;

    localparam int unsigned MAT_W = ELEM_W * DIM * DIM;
    localparam int unsigned OFF_W = $clog2(MAT_W);
    localparam logic [4:0]  LAST  = 5'(DIM * DIM - 1);

    mpu_state_e       state;
    logic             xfer;
    logic [OFF_W-1:0] wr_off;

    // in_ready is combinational on clear so a clear cycle never accepts.
    assign in_ready = (state == LOAD) && !clear;
    assign xfer     = in_valid && in_ready;

    always_comb begin
        wr_off = '0;
        wr_off = OFF_W'(elem_offset(int'(count) / DIM, int'(count) % DIM,
                                    ELEM_W, DIM));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            count     <= '0;
            matrix    <= '0;
            out_valid <= 1'b0;
            err_len   <= 1'b0;
        end else begin
            err_len <= 1'b0;
            if (clear) begin
                // Abort: matrix contents are deliberately left untouched.
                state     <= LOAD;
                count     <= '0;
                out_valid <= 1'b0;
            end else begin
                unique case (state)
                    LOAD: begin
                        if (xfer) begin
                            matrix[wr_off +: ELEM_W] <= in_data;
                            if (count == LAST) begin
                                // Frame completes on length; a missing
                                // in_last is flagged but not fatal.
                                count     <= '0;
                                state     <= HOLD;
                                out_valid <= 1'b1;
                                err_len   <= !in_last;
                            end else if (in_last) begin
                                // Short frame: drop it, partial data stays
                                // in matrix but is never presented.
                                count   <= '0;
                                err_len <= 1'b1;
                            end else begin
                                count <= count + 5'd1;
                            end
                        end
                    end
                    HOLD: begin
                        if (out_ready) begin
                            state     <= LOAD;
                            out_valid <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= LOAD;
                        out_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// tb_mpu_matrix_loader
//   Self-checking bench for mpu_matrix_loader. A cycle model tracks the
//   expected handshake/counter state; completed frames are pushed to a
//   scoreboard queue and popped when the DUT hands the matrix off.
module tb_mpu_matrix_loader;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [199:0]      matrix;
    logic [4:0]        count;
    logic              err_len;

    int vectors     = 0;
    int miscompares = 0;

    // Cycle model
    logic [199:0] mmat;
    int           mcount;
    bit           mhold;
    bit           merr;
    logic [199:0] sbq[$];

    mpu_matrix_loader #(.ELEM_W(8), .DIM(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .matrix    (matrix),
        .count     (count),
        .err_len   (err_len)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mmat   = '0;
        mcount = 0;
        mhold  = 1'b0;
        merr   = 1'b0;
        sbq.delete();
    endtask

    // One clock cycle: drive inputs, check in_ready and any handoff before
    // the edge, advance the model, then check registered outputs after it.
    task automatic step(input bit v, input logic [7:0] d, input bit last,
                        input bit clr, input bit ordy, output bit acc);
        logic [199:0] exp_m;
        in_valid  = v;
        in_data   = d;
        in_last   = last;
        clear     = clr;
        out_ready = ordy;
        #1;
        vectors++;
        if (in_ready !== (!mhold && !clr)) begin
            miscompares++;
            $display("FAIL in_ready: got %b expected %b", in_ready, !mhold && !clr);
        end
        acc = v && !mhold && !clr;
        if (mhold && ordy && !clr) begin
            vectors++;
            if (sbq.size() == 0) begin
                miscompares++;
                $display("FAIL handoff: out_valid with no expected frame");
            end else begin
                exp_m = sbq.pop_front();
                if (matrix !== exp_m) begin
                    miscompares++;
                    $display("FAIL handoff_matrix: got %h expected %h", matrix, exp_m);
                end
            end
        end else if (mhold && clr && sbq.size() > 0) begin
            void'(sbq.pop_front());
        end
        // model update
        merr = 1'b0;
        if (clr) begin
            mhold  = 1'b0;
            mcount = 0;
        end else if (!mhold) begin
            if (v) begin
                mmat[mcount*8 +: 8] = d;
                if (mcount == 24) begin
                    mcount = 0;
                    mhold  = 1'b1;
                    merr   = !last;
                    sbq.push_back(mmat);
                end else if (last) begin
                    mcount = 0;
                    merr   = 1'b1;
                end else begin
                    mcount++;
                end
            end
        end else if (ordy) begin
            mhold = 1'b0;
        end
        @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== mhold) begin
            miscompares++;
            $display("FAIL out_valid: got %b expected %b", out_valid, mhold);
        end
        vectors++;
        if (count !== 5'(mcount)) begin
            miscompares++;
            $display("FAIL count: got %0d expected %0d", count, mcount);
        end
        vectors++;
        if (err_len !== merr) begin
            miscompares++;
            $display("FAIL err_len: got %b expected %b", err_len, merr);
        end
        vectors++;
        if (matrix !== mmat) begin
            miscompares++;
            $display("FAIL matrix: got %h expected %h", matrix, mmat);
        end
    endtask

    task automatic idle(input bit ordy);
        bit acc;
        step(1'b0, 8'h00, 1'b0, 1'b0, ordy, acc);
    endtask

    // Sends n elements back-to-back starting at value base (step by inc).
    task automatic send_frame(input int n, input int base, input int inc,
                              input bit last_on_end);
        bit acc;
        for (int k = 0; k < n; k++) begin
            step(1'b1, 8'(base + inc * k), last_on_end && (k == n - 1), 1'b0, 1'b1, acc);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
        in_last = 1'b0; out_ready = 1'b0;
        model_reset();
        #1;
        vectors++;
        if (out_valid !== 1'b0 || err_len !== 1'b0 || count !== 5'd0 || matrix !== 200'd0) begin
            miscompares++;
            $display("FAIL reset_state: out_valid=%b err_len=%b count=%0d matrix=%h expected 0 0 0 0",
                     out_valid, err_len, count, matrix);
        end
        #11 rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
    endtask

    task automatic test_stream();
        logic [199:0] tr;
        logic [199:0] exp_tr;
        bit acc;
        for (int k = 0; k < 25; k++)
            step(1'b1, 8'(k + 1), k == 24, 1'b0, 1'b0, acc);
        vectors++;
        if (matrix[7:0] !== 8'd1) begin
            miscompares++;
            $display("FAIL stream_first: got %0d expected 1", matrix[7:0]);
        end
        vectors++;
        if (matrix[199:192] !== 8'd25) begin
            miscompares++;
            $display("FAIL stream_last: got %0d expected 25", matrix[199:192]);
        end
        // Transpose as the downstream stage would; element (i,j) of the
        // transpose must be 5*j + i + 1.
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                tr[8*(j+5*i) +: 8]     = matrix[8*(i+5*j) +: 8];
                exp_tr[8*(j+5*i) +: 8] = 8'(5*j + i + 1);
            end
        end
        vectors++;
        if (tr !== exp_tr) begin
            miscompares++;
            $display("FAIL stream_transpose: got %h expected %h", tr, exp_tr);
        end
        idle(1'b1);
    endtask

    task automatic test_short_frame();
        send_frame(10, 100, 1, 1'b1);
        idle(1'b1);
        send_frame(25, -1, -1, 1'b1);
        vectors++;
        if (matrix[7:0] !== 8'hFF || matrix[199:192] !== 8'hE7) begin
            miscompares++;
            $display("FAIL neg_frame: got first=%h last=%h expected ff e7",
                     matrix[7:0], matrix[199:192]);
        end
        idle(1'b1);
    endtask

    task automatic test_backpressure();
        bit acc;
        for (int k = 0; k < 25; k++)
            step(1'b1, 8'(8'h40 + k), k == 24, 1'b0, 1'b0, acc);
        for (int c = 0; c < 10; c++)
            step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, acc);
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, acc);
        vectors++;
        if (acc !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_no_bypass: handoff cycle accepted an element");
        end
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_ready_after: got %b expected 1", in_ready);
        end
        in_valid = 1'b0;
        idle(1'b1);
    endtask

    task automatic test_gaps();
        logic [199:0] ref_m;
        bit acc;
        int k = 0;
        int cyc = 0;
        for (int i = 0; i < 25; i++) ref_m[8*i +: 8] = 8'(i + 1);
        while (k < 25 && cyc < 300) begin
            if ($urandom_range(0, 1) == 1) begin
                step(1'b1, 8'(k + 1), k == 24, 1'b0, 1'b0, acc);
                if (acc) k++;
            end else begin
                step(1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, acc);
            end
            cyc++;
        end
        vectors++;
        if (k != 25) begin
            miscompares++;
            $display("FAIL gaps_timeout: accepted %0d expected 25", k);
        end
        vectors++;
        if (matrix !== ref_m) begin
            miscompares++;
            $display("FAIL gaps_frame: got %h expected %h", matrix, ref_m);
        end
        idle(1'b1);
    endtask

    task automatic test_clear();
        bit acc;
        for (int k = 0; k < 12; k++)
            step(1'b1, 8'(8'h10 + k), 1'b0, 1'b0, 1'b1, acc);
        step(1'b1, 8'h77, 1'b0, 1'b1, 1'b1, acc);
        vectors++;
        if (count !== 5'd0 || acc) begin
            miscompares++;
            $display("FAIL clear_count: got %0d expected 0", count);
        end
        send_frame(25, 8'h20, 1, 1'b1);
        idle(1'b1);
    endtask

    task automatic test_back_to_back();
        bit acc;
        int n = 0;
        for (int c = 0; c < 52; c++) begin
            step(1'b1, 8'(n), 1'b0, 1'b0, 1'b1, acc);
            if (acc) n++;
        end
        vectors++;
        if (n != 50) begin
            miscompares++;
            $display("FAIL b2b_rate: accepted %0d expected 50", n);
        end
        vectors++;
        if (sbq.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_drain: %0d frames pending expected 0", sbq.size());
        end
    endtask

    task automatic test_async_reset();
        bit acc;
        for (int k = 0; k < 7; k++)
            step(1'b1, 8'(8'h30 + k), 1'b0, 1'b0, 1'b1, acc);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (count !== 5'd0 || out_valid !== 1'b0 || err_len !== 1'b0 || matrix !== 200'd0) begin
            miscompares++;
            $display("FAIL async_reset: count=%0d out_valid=%b err_len=%b matrix=%h expected 0 0 0 0",
                     count, out_valid, err_len, matrix);
        end
        model_reset();
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(1'b1);
        idle(1'b1);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_short_frame();
        test_backpressure();
        test_gaps();
        test_clear();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mpu_matrix_loader.md
MPU_MATRIX_LOADER -- requirements
Module: mpu_matrix_loader

Interface
REQ-001 The block SHALL have parameter ELEM_W, default 8, the signed element width in bits.
REQ-002 The block SHALL have parameter DIM, default 5, the matrix dimension; matrix width is ELEM_W*DIM*DIM (200).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port clear, input, 1, synchronous frame abort.
REQ-006 The block SHALL have port in_valid, input, 1, meaning in_data holds an element.
REQ-007 The block SHALL have port in_ready, output, 1, meaning the block accepts an element this cycle.
REQ-008 The block SHALL have port in_data, input, ELEM_W, the signed element.
REQ-009 The block SHALL have port in_last, input, 1, a producer mark on the final element of a frame.
REQ-010 The block SHALL have port out_valid, output, 1, meaning matrix holds a complete frame.
REQ-011 The block SHALL have port out_ready, input, 1, meaning downstream (the transpose stage) takes the matrix.
REQ-012 The block SHALL have port matrix, output, ELEM_W*DIM*DIM, the flat signed matrix, registered.
REQ-013 The block SHALL have port count, output, 5, the number of elements accepted in the current frame.
REQ-014 The block SHALL have port err_len, output, 1, a one-cycle framing-error pulse.

Function
REQ-015 A transfer SHALL occur exactly when in_valid and in_ready are both high at a rising clk edge.
REQ-016 The FSM SHALL have two states: LOAD (in_ready = !clear) and HOLD (in_ready = 0, out_valid = 1).
REQ-017 The k-th accepted element (k = count, 0..24) SHALL be written to matrix bits [8k+7:8k], i.e. outer index i = k/5 and inner index j = k%5 at offset 8*(j+5*i), row-major.
REQ-018 Each transfer with count < 24 SHALL increment count by 1 and stay in LOAD.
REQ-019 A transfer with count == 24 SHALL write element 24, set count to 0, and move to HOLD; out_valid SHALL rise on the next cycle (latency 1 cycle after the 25th transfer).
REQ-020 In HOLD, matrix and out_valid SHALL stay stable until out_valid && out_ready; the block SHALL then return to LOAD, with in_ready high on the following cycle and no same-cycle bypass.
REQ-021 A transfer with in_last = 1 and count < 24 SHALL discard the frame: count to 0, stay in LOAD, err_len pulses for 1 cycle, and already-written elements remain in matrix but are never presented.
REQ-022 A transfer with count == 24 and in_last = 0 SHALL still complete the frame (REQ-019) and SHALL pulse err_len.
REQ-023 clear SHALL take priority over all other events: state to LOAD, count to 0, out_valid to 0, err_len to 0, and matrix unchanged; an in_valid element in a clear cycle SHALL NOT be accepted.
REQ-024 The sustained rate SHALL be one matrix per 26 cycles: 25 loads plus 1 handoff, with out_ready held high.
REQ-025 The matrix register SHALL NOT be cleared on handoff; the next frame overwrites elements one by one.

Reset
REQ-026 While rst_n = 0, the block SHALL asynchronously set state to LOAD, count to 0, matrix to all zeros, out_valid to 0 and err_len to 0.
REQ-027 On rst_n release, in_ready SHALL be 1 from the first clk edge onward.
REQ-028 A reset asserted mid-frame or in HOLD SHALL discard the frame with no err_len pulse.

Structure
REQ-029 ELEM_W, DIM, MATRIX_W, the element-offset function 8*(j+5*i) and the LOAD/HOLD state encoding SHALL live in the shared mpu_pkg, common with the transpose stage.
REQ-030 The block SHALL be a single module with no sub-module; the counter and FSM are too small to split.

Verification
REQ-031 The bench SHALL stream elements 1..25 back-to-back with in_last on 25 and out_ready=1 -> out_valid one cycle after the 25th transfer, matrix[7:0]=1, matrix[199:192]=25, and a transposed result matching once fed to the transpose stage.
REQ-032 The bench SHALL assert in_last on the 10th element -> err_len pulse, count=0, no out_valid; a following good frame of -1..-25 is presented correctly.
REQ-033 The bench SHALL hold out_ready=0 for 10 cycles after a full frame -> in_ready=0 and matrix stable throughout; on out_ready=1, in_ready=1 on the next cycle.
REQ-034 The bench SHALL apply random in_valid gaps (about 50%) -> frame identical to the gap-free case, with count tracking transfers exactly.
REQ-035 The bench SHALL assert clear together with in_valid at count=12 -> element not accepted, count=0, and a subsequent 25-element frame is presented intact.
REQ-036 The bench SHALL pulse rst_n low asynchronously mid-frame (count=7) -> outputs go to reset values immediately, with no err_len and no out_valid.
